apb_regfile_ctrl: RTL
=====================

// Module: apb_regfile_ctrl
// PURPOSE
//  APB3/APB4 slave front-end that sequences accesses into the 16-entry register file.
//  Decodes and range-checks PADDR, then issues a one-cycle RegENABLE command.
//  Waits for RegREADY with a timeout, then completes the APB transfer with PREADY/PSLVERR.
//  Sits between the APB interconnect and the register file. No other block drives the Reg* side.
// PARAMETERS
//  ADDR_WIDTH  32              APB/register address width
//  DATA_WIDTH  32              APB/register data width
//  STRB_WIDTH  DATA_WIDTH/8    byte-strobe width
//  NUM_REGS    16              implemented word registers at 0x00..(NUM_REGS*4-4)
//  TIMEOUT     15              WAIT cycles without RegREADY before error completion (>=1)
// PORTS
//  PCLK       in   1           clock
//  PRESETn    in   1           reset, asynchronous, active-low
//  PSEL       in   1           APB select
//  PENABLE    in   1           APB access phase
//  PWRITE     in   1           1=write, 0=read
//  PADDR      in   ADDR_WIDTH  byte address
//  PWDATA     in   DATA_WIDTH  write data
//  PSTRB      in   STRB_WIDTH  write byte strobes
//  PRDATA     out  DATA_WIDTH  read data, registered
//  PREADY     out  1           transfer complete
//  PSLVERR    out  1           transfer error, valid only with PREADY
//  RegADDR    out  ADDR_WIDTH  latched register address
//  RegWDATA   out  DATA_WIDTH  latched write data
//  RegWRITE   out  1           latched direction
//  RegENABLE  out  1           one-cycle command pulse
//  RegSTRB    out  STRB_WIDTH  latched strobes (forced 0 on reads)
//  RegRDATA   in   DATA_WIDTH  register read data, valid while RegREADY=1
//  RegSLVERR  in   1           register error, sampled with RegREADY
//  RegREADY   in   1           register accepted/returned; high the cycle after RegENABLE
// BEHAVIOUR
//  Reset: async assert forces state=IDLE and zeroes every output and the timeout counter.
//   Applies even mid-transfer; a command already issued is not retracted.
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//  IDLE
//   On PSEL=1 & PENABLE=0 (setup phase), latch PADDR/PWDATA/PWRITE/PSTRB into the Reg* outputs.
//   Set err_pend=1 if PADDR[1:0]!=0 or PADDR>=NUM_REGS*4.
//   Set nop_pend=1 if PWRITE=1 & PSTRB==0.
//   If err_pend or nop_pend -> DONE, with no RegENABLE. Otherwise -> ISSUE.
//  ISSUE
//   RegENABLE=1 for exactly this cycle; -> WAIT; clear the timeout counter.
//  WAIT
//   RegENABLE=0.
//   If RegREADY=1: capture RegRDATA into PRDATA (reads only), capture RegSLVERR; -> DONE.
//   Else increment the counter. At count==TIMEOUT -> DONE with error.
//  DONE
//   PREADY=1 for exactly one cycle. PSLVERR=err_pend|RegSLVERR_captured|timeout.
//   -> IDLE; sticky flags cleared.
//  Latency: nominal access phase = PREADY in the 3rd PENABLE cycle (2 wait states).
//   Error/nop accesses take 1 wait state.
//  PRDATA holds its last read value across writes. It is set to 0 on any errored read.
//  PSEL=0 in ISSUE/WAIT/DONE (protocol abort) -> IDLE next cycle.
//   In that case PREADY stays 0; an issued write still lands in the register file.
//  A back-to-back setup phase in the DONE cycle is ignored. The master must return through IDLE.
//  RegREADY in IDLE/ISSUE is ignored. RegSTRB=0 and RegWDATA are don't-care on reads.
// TESTING
//  Write 0x0000_0010, PWDATA=0xDEADBEEF, PSTRB=0xF
//   -> one RegENABLE pulse, PREADY at 3rd access cycle, PSLVERR=0.
//  Read 0x10 after the above
//   -> PRDATA=0xDEADBEEF with PREADY, PSLVERR=0.
//  Read 0x40 and read 0x06
//   -> no RegENABLE, PREADY after 1 wait, PSLVERR=1, PRDATA=0.
//  Write with PSTRB=0x0 to 0x08
//   -> no RegENABLE, PREADY after 1 wait, PSLVERR=0.
//  Hold RegREADY=0 (stubbed)
//   -> PREADY with PSLVERR=1 exactly TIMEOUT=15 cycles after entering WAIT.
//  Assert PRESETn=0 during WAIT
//   -> all outputs 0 immediately (async); next setup phase is serviced normally.

Source files
------------

// File: rtl/apb_regfile_ctrl_if.sv
// APB slave-side bus bundle for apb_regfile_ctrl.
//  master : drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB, receives PRDATA/PREADY/PSLVERR
//  slave  : the reverse
interface apb_regfile_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_regfile_ctrl.sv
// APB3/APB4 slave front-end sequencing accesses into a word register file.
// Decodes/range-checks PADDR, issues a one-cycle RegENABLE, waits for RegREADY
// (bounded by TIMEOUT) and completes the APB transfer with PREADY/PSLVERR.
//  PCLK, PRESETn : clock, asynchronous active-low reset
//  apb           : APB slave bus (PSEL..PSTRB in, PRDATA/PREADY/PSLVERR out)
//  Reg*          : register-file command side (address/data/strobe/direction
//                  latched at setup, RegENABLE pulse, RegREADY/RegRDATA/RegSLVERR back)
module apb_regfile_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  apb_regfile_ctrl_if.slave     apb,
  output logic [ADDR_WIDTH-1:0] RegADDR,
  output logic [DATA_WIDTH-1:0] RegWDATA,
  output logic                  RegWRITE,
  output logic                  RegENABLE,
  output logic [STRB_WIDTH-1:0] RegSTRB,
  input  logic [DATA_WIDTH-1:0] RegRDATA,
  input  logic                  RegSLVERR,
  input  logic                  RegREADY
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);

  logic [1:0]            state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic                  err_q,    err_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic                  write_q,  write_d;
  logic [STRB_WIDTH-1:0] strb_q,   strb_d;
  logic                  bad_addr, nop_wr;

  assign bad_addr = (apb.PADDR[1:0] != 2'b00) || (apb.PADDR >= ADDR_LIMIT);
  assign nop_wr   = apb.PWRITE && (apb.PSTRB == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pready_d = 1'b0;
    prdata_d = prdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    strb_d   = strb_q;
    case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          addr_d  = apb.PADDR;
          wdata_d = apb.PWDATA;
          write_d = apb.PWRITE;
          strb_d  = apb.PWRITE ? apb.PSTRB : '0;
          err_d   = bad_addr;
          if (bad_addr || nop_wr) begin
            state_d = DONE;
            if (bad_addr && !apb.PWRITE) prdata_d = '0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = apb.PSEL ? WAIT : IDLE;
      end
      WAIT: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else if (RegREADY) begin
          err_d    = err_q | RegSLVERR;
          if (!write_q) prdata_d = RegSLVERR ? '0 : RegRDATA;
          state_d  = DONE;
          pready_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          err_d    = 1'b1;
          if (!write_q) prdata_d = '0;
          state_d  = DONE;
          pready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin // DONE
        // Completions from WAIT enter DONE with PREADY already raised. Decode
        // errors and no-op writes arrive straight from IDLE, so they spend one
        // DONE cycle with PREADY low first, giving the master one wait state.
        if (!apb.PSEL || pready_q) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end else begin
          pready_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      strb_q   <= strb_d;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pready_q & err_q;
  assign RegADDR     = addr_q;
  assign RegWDATA    = wdata_q;
  assign RegWRITE    = write_q;
  assign RegSTRB     = strb_q;
  assign RegENABLE   = (state_q == ISSUE);

endmodule
